ddr2sdr_pack: RTL and testbench

Packs a stream clocked at the double-rate clock into double-width words for capture by the single-rate clock domain. It is the DDR→SDR counterpart of the SDR→DDR clock follower, and consumes that follower's output as its phase reference. It sits entirely in the DDR domain, next to the follower. It holds every outgoing word stable for two DDR cycles, straddling exactly one SDR rising edge.

---
 rtl/ddr2sdr_pkg.sv | 17 +
 rtl/ddr2sdr_lock.sv | 67 ++++++
 rtl/ddr2sdr_pack.sv | 130 +++++++++++++
 tb/tb_ddr2sdr_pack.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2sdr_pkg.sv
// Shared types and constants for the DDR-to-SDR beat packer.
package ddr2sdr_pkg;

  typedef enum logic {
    LOCK_UNLOCKED = 1'b0,
    LOCK_LOCKED   = 1'b1
  } lock_state_e;

  typedef logic [1:0] mask_t;

  localparam mask_t MASK_LO   = 2'b01;
  localparam mask_t MASK_BOTH = 2'b11;

  // Wide enough for LOCK_CNT up to 15.
  localparam int unsigned LOCK_CNT_W = 4;

endpackage

// File: rtl/ddr2sdr_lock.sv
// Phase lock on the SDR follower: it qualifies alternating follow samples and
// marks the DDR edges that sit between SDR rising edges.
module ddr2sdr_lock
  import ddr2sdr_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic clk_ddr_i,
  input  logic rst_ddr_ni,
  input  logic follow_i,
  output logic locked_o,
  output logic upd_edge_o,
  output logic lose_o,
  output logic lock_err_o
);

  lock_state_e           state_q, state_d;
  logic                  follow_q;
  logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;
  logic                  alt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lose_o  = 1'b0;
    alt     = (follow_i != follow_q);
    case (state_q)
      LOCK_UNLOCKED: begin
        if (!alt) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_CNT_W'(LOCK_CNT - 1)) begin
          state_d = LOCK_LOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LOCK_CNT_W'(1);
        end
      end
      LOCK_LOCKED: begin
        if (!alt) begin
          state_d = LOCK_UNLOCKED;
          lose_o  = 1'b1;
        end
      end
      default: state_d = LOCK_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_ddr_i or negedge rst_ddr_ni) begin
    if (!rst_ddr_ni) begin
      state_q    <= LOCK_UNLOCKED;
      follow_q   <= 1'b0;
      cnt_q      <= '0;
      lock_err_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      follow_q <= follow_i;
      cnt_q    <= cnt_d;
      if (lose_o) begin
        lock_err_o <= 1'b1;
      end
    end
  end

  assign locked_o   = (state_q == LOCK_LOCKED);
  assign upd_edge_o = locked_o && follow_i;

endmodule

// File: rtl/ddr2sdr_pack.sv
// Packs DDR-rate beats into double-width words, updating outputs only on DDR
// edges between SDR rising edges so each word straddles one SDR capture.
module ddr2sdr_pack
  import ddr2sdr_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic          clk_ddr_i,
  input  logic          rst_ddr_ni,
  input  logic          follow_i,
  input  logic          s_valid_i,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_last_i,
  output logic          s_ready_o,
  output logic          sdr_valid_o,
  output logic [2*DW-1:0] sdr_data_o,
  output logic [1:0]    sdr_mask_o,
  output logic          sdr_last_o,
  input  logic          sdr_ready_i,
  output logic          locked_o,
  output logic          lock_err_o
);

  localparam int unsigned WW = 2 * DW;

  typedef struct packed {
    logic [WW-1:0] data;
    mask_t         mask;
    logic          last;
  } pend_t;

  logic          locked, upd_edge, lose;
  logic [DW-1:0] lo_q;
  logic          lo_v_q, lo_last_q;
  pend_t         pend_q, pend_d, out_q;
  logic          pend_v_q, out_v_q;
  logic          accept, pend_mv, pend_free;
  logic          pair, single, park, store_lo, flush, pend_load;

  ddr2sdr_lock #(
    .LOCK_CNT(LOCK_CNT)
  ) u_lock (
    .clk_ddr_i (clk_ddr_i),
    .rst_ddr_ni(rst_ddr_ni),
    .follow_i  (follow_i),
    .locked_o  (locked),
    .upd_edge_o(upd_edge),
    .lose_o    (lose),
    .lock_err_o(lock_err_o)
  );

  assign s_ready_o = locked && !(pend_v_q && lo_v_q);
  assign accept    = s_valid_i && s_ready_o;
  assign pend_mv   = upd_edge && !lose && pend_v_q && (!out_v_q || sdr_ready_i);
  assign pend_free = !pend_v_q || pend_mv;

  // A lone last beat that finds pend occupied is parked in lo and flushed as a
  // half word once pend drains; the register-only ready then stalls the next beat.
  assign pair     = accept && lo_v_q;
  assign single   = accept && !lo_v_q && s_last_i && pend_free;
  assign park     = accept && !lo_v_q && s_last_i && !pend_free;
  assign store_lo = accept && !lo_v_q && !s_last_i;
  assign flush    = lo_v_q && lo_last_q && pend_free;
  assign pend_load = pair || single || flush;

  always_comb begin
    pend_d = pend_q;
    if (pair) begin
      pend_d.data = {s_data_i, lo_q};
      pend_d.mask = MASK_BOTH;
      pend_d.last = s_last_i;
    end else if (single) begin
      pend_d.data = {{DW{1'b0}}, s_data_i};
      pend_d.mask = MASK_LO;
      pend_d.last = 1'b1;
    end else if (flush) begin
      pend_d.data = {{DW{1'b0}}, lo_q};
      pend_d.mask = MASK_LO;
      pend_d.last = 1'b1;
    end
  end

  always_ff @(posedge clk_ddr_i or negedge rst_ddr_ni) begin
    if (!rst_ddr_ni) begin
      lo_q      <= '0;
      lo_v_q    <= 1'b0;
      lo_last_q <= 1'b0;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      out_q     <= '0;
      out_v_q   <= 1'b0;
    end else if (lose) begin
      lo_v_q    <= 1'b0;
      lo_last_q <= 1'b0;
      pend_v_q  <= 1'b0;
      out_v_q   <= 1'b0;
    end else begin
      if (store_lo || park) begin
        lo_q      <= s_data_i;
        lo_v_q    <= 1'b1;
        lo_last_q <= park;
      end else if (pair || flush) begin
        lo_v_q    <= 1'b0;
        lo_last_q <= 1'b0;
      end

      if (pend_load) begin
        pend_q   <= pend_d;
        pend_v_q <= 1'b1;
      end else if (pend_mv) begin
        pend_v_q <= 1'b0;
      end

      if (pend_mv) begin
        out_q   <= pend_q;
        out_v_q <= 1'b1;
      end else if (upd_edge && out_v_q && sdr_ready_i) begin
        out_v_q <= 1'b0;
      end
    end
  end

  assign locked_o    = locked;
  assign sdr_valid_o = out_v_q;
  assign sdr_data_o  = out_q.data;
  assign sdr_mask_o  = out_q.mask;
  assign sdr_last_o  = out_q.last;

endmodule

// File: tb/tb_ddr2sdr_pack.sv
// Directed bench for ddr2sdr_pack with a scoreboard of expected output words.
module tb_ddr2sdr_pack;

  localparam int unsigned DW       = 8;
  localparam int unsigned LOCK_CNT = 4;

  logic            clk_ddr   = 1'b0;
  logic            rst_n     = 1'b0;
  logic            follow    = 1'b0;
  logic            s_valid   = 1'b0;
  logic [DW-1:0]   s_data    = '0;
  logic            s_last    = 1'b0;
  logic            sdr_ready = 1'b0;
  logic            s_ready_o, sdr_valid_o, sdr_last_o, locked_o, lock_err_o;
  logic [2*DW-1:0] sdr_data_o;
  logic [1:0]      sdr_mask_o;

  typedef struct {
    logic [2*DW-1:0] data;
    logic [1:0]      mask;
    logic            last;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m_lo;
  logic          m_lo_v = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;
  int            hold_cnt = 0;
  int            hold_done = 0;

  ddr2sdr_pack #(
    .DW      (DW),
    .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk_ddr_i  (clk_ddr),
    .rst_ddr_ni (rst_n),
    .follow_i   (follow),
    .s_valid_i  (s_valid),
    .s_data_i   (s_data),
    .s_last_i   (s_last),
    .s_ready_o  (s_ready_o),
    .sdr_valid_o(sdr_valid_o),
    .sdr_data_o (sdr_data_o),
    .sdr_mask_o (sdr_mask_o),
    .sdr_last_o (sdr_last_o),
    .sdr_ready_i(sdr_ready),
    .locked_o   (locked_o),
    .lock_err_o (lock_err_o)
  );

  always #5 clk_ddr = ~clk_ddr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Follower: toggles just after each DDR edge; a hold request repeats a 0.
  task automatic follow_gen();
    forever begin
      @(posedge clk_ddr);
      #1;
      if (hold_cnt != hold_done && !follow) hold_done++;
      else follow = ~follow;
    end
  endtask

  // Watches each coming edge from the preceding falling edge.
  task automatic monitor();
    logic            last_f = 1'b0, prev_ok = 1'b0, prev_upd = 1'b0;
    logic [2*DW-1:0] p_data;
    logic [1:0]      p_mask;
    logic            p_last;
    logic            loss, upd;
    exp_t            e;
    forever begin
      @(negedge clk_ddr);
      if (!rst_n) begin
        last_f  = 1'b0;
        prev_ok = 1'b0;
      end else begin
        if (prev_ok && !prev_upd) begin
          chk("hold_data", 32'(sdr_data_o), 32'(p_data));
          chk("hold_mask", 32'(sdr_mask_o), 32'(p_mask));
          chk("hold_last", 32'(sdr_last_o), 32'(p_last));
        end
        loss = locked_o && (follow == last_f);
        upd  = locked_o && follow && !loss;
        if (loss) begin
          sb.delete();
          m_lo_v = 1'b0;
        end else if (upd && sdr_valid_o && sdr_ready) begin
          chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("word_data", 32'(sdr_data_o), 32'(e.data));
            chk("word_mask", 32'(sdr_mask_o), 32'(e.mask));
            chk("word_last", 32'(sdr_last_o), 32'(e.last));
          end
        end
        prev_upd = upd;
        prev_ok  = 1'b1;
        p_data   = sdr_data_o;
        p_mask   = sdr_mask_o;
        p_last   = sdr_last_o;
        last_f   = follow;
      end
    end
  endtask

  task automatic model_accept(input logic [DW-1:0] d, input logic l);
    exp_t e;
    if (!m_lo_v && !l) begin
      m_lo   = d;
      m_lo_v = 1'b1;
    end else begin
      if (!m_lo_v) begin
        e.data = {8'h00, d};
        e.mask = 2'b01;
        e.last = 1'b1;
      end else begin
        e.data = {d, m_lo};
        e.mask = 2'b11;
        e.last = l;
      end
      m_lo_v = 1'b0;
      sb.push_back(e);
    end
  endtask

  // Called at posedge+1; s_ready_o then governs the next edge.
  task automatic send(input logic [DW-1:0] d, input logic l);
    int unsigned w = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready_o && w < 50) begin
      @(posedge clk_ddr);
      #1;
      w++;
    end
    chk("send_accept", 32'(w < 50), 32'd1);
    if (w < 50) model_accept(d, l);
    @(posedge clk_ddr);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk_ddr);
      #1;
    end
  endtask

  task automatic drain();
    int unsigned w = 0;
    while ((sb.size() != 0 || sdr_valid_o) && w < 60) begin
      @(posedge clk_ddr);
      #1;
      w++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_idle", 32'(sdr_valid_o), 32'd0);
  endtask

  task automatic release_and_lock();
    int unsigned w = 0;
    @(negedge clk_ddr);
    while (!follow && w < 4) begin
      @(negedge clk_ddr);
      w++;
    end
    #2 rst_n = 1'b1;
    for (int unsigned i = 1; i <= LOCK_CNT; i++) begin
      @(posedge clk_ddr);
      #1;
      chk("lock_latency", 32'(locked_o), 32'(i == LOCK_CNT));
      chk("ready_at_lock", 32'(s_ready_o), 32'(i == LOCK_CNT));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready_o), 32'd0);
    chk({tag, "_valid"},   32'(sdr_valid_o), 32'd0);
    chk({tag, "_data"},    32'(sdr_data_o), 32'd0);
    chk({tag, "_mask"},    32'(sdr_mask_o), 32'd0);
    chk({tag, "_last"},    32'(sdr_last_o), 32'd0);
    chk({tag, "_locked"},  32'(locked_o), 32'd0);
    chk({tag, "_err"},     32'(lock_err_o), 32'd0);
  endtask

  initial begin
    int unsigned n_acc;
    int unsigned w;
    logic [DW-1:0] b;
    fork
      follow_gen();
      monitor();
    join_none

    cycles(3);
    check_zero_outputs("reset");
    release_and_lock();

    // Back-to-back pairs.
    sdr_ready = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    drain();

    // Odd burst: trailing beat goes out zero-filled.
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b1);
    drain();

    // Consumer stall with a continuous stream.
    sdr_ready = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    cycles(4);
    chk("bp_out_valid", 32'(sdr_valid_o), 32'd1);
    n_acc = 0;
    b = 8'h03;
    while (n_acc < 10) begin
      s_valid = 1'b1;
      s_data  = b;
      s_last  = 1'b0;
      if (!s_ready_o) break;
      model_accept(b, 1'b0);
      @(posedge clk_ddr);
      #1;
      n_acc++;
      b = b + 8'h01;
    end
    chk("bp_accepted", 32'(n_acc), 32'd3);
    cycles(3);
    chk("bp_ready_low", 32'(s_ready_o), 32'd0);
    chk("bp_frozen", 32'(sdr_data_o), 32'h0201);
    sdr_ready = 1'b1;
    send(b, 1'b0);
    send(b + 8'h01, 1'b1);
    drain();

    // Lock loss with data in flight.
    sdr_ready = 1'b0;
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    cycles(2);
    hold_cnt++;
    w = 0;
    while (locked_o && w < 10) begin
      @(posedge clk_ddr);
      #1;
      w++;
    end
    chk("loss_locked", 32'(locked_o), 32'd0);
    chk("loss_err", 32'(lock_err_o), 32'd1);
    chk("loss_valid", 32'(sdr_valid_o), 32'd0);
    w = 0;
    while (!locked_o && w < 20) begin
      @(posedge clk_ddr);
      #1;
      w++;
    end
    chk("relock", 32'(locked_o), 32'd1);
    chk("err_sticky", 32'(lock_err_o), 32'd1);
    sdr_ready = 1'b1;
    send(8'hB1, 1'b1);
    drain();
    chk("err_sticky2", 32'(lock_err_o), 32'd1);

    // Asynchronous reset with a beat parked in lo.
    sdr_ready = 1'b0;
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b0);
    cycles(2);
    chk("pre_rst_valid", 32'(sdr_valid_o), 32'd1);
    @(negedge clk_ddr);
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    sb.delete();
    m_lo_v = 1'b0;
    cycles(2);
    release_and_lock();
    sdr_ready = 1'b1;
    send(8'hE5, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
